// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot exit and entry sides.
// Holds the gate FSM encoding and the free-slot counter width.
package parking_pkg;

    localparam int CAP_W = 8;

    localparam logic [CAP_W-1:0] DEFAULT_CAPACITY = 8'd200;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2
    } exit_state_e;

endpackage

// File: rtl/parking_exit_controller_if.sv
// Exit gate signal bundle between the lot environment and the controller.
// The controller takes the slave view, the environment the master view.
interface parking_exit_controller_if;

    logic                          exit_req;
    logic                          car_passed;
    logic                          entry_taken;
    logic [parking_pkg::CAP_W-1:0] parking_capacity;
    logic                          gate_open;
    logic                          exit_done;
    logic                          exit_reject;
    logic                          err_timeout;
    logic                          err_overflow;

    modport master (
        output exit_req,
        output car_passed,
        output entry_taken,
        input  parking_capacity,
        input  gate_open,
        input  exit_done,
        input  exit_reject,
        input  err_timeout,
        input  err_overflow
    );

    modport slave (
        input  exit_req,
        input  car_passed,
        input  entry_taken,
        output parking_capacity,
        output gate_open,
        output exit_done,
        output exit_reject,
        output err_timeout,
        output err_overflow
    );

endinterface

// File: rtl/slot_counter.sv
// Saturating up/down free-slot counter bounded by 0 and CAPACITY.
// A bound violation holds the count and sets a sticky overflow flag.
module slot_counter
    import parking_pkg::*;
#(
    parameter logic [CAP_W-1:0] CAPACITY = DEFAULT_CAPACITY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CAP_W-1:0] count,
    output logic             overflow
);

    logic [CAP_W-1:0] count_d;
    logic             overflow_d;

    // Next count: simultaneous inc/dec cancel, bounds saturate and flag.
    always_comb begin
        count_d    = count;
        overflow_d = overflow;
        if (inc && !dec) begin
            if (count == CAPACITY) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count + CAP_W'(1);
            end
        end else if (dec && !inc) begin
            if (count == '0) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count - CAP_W'(1);
            end
        end
    end

    // Count and sticky flag registers; reset returns a full set of slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= CAPACITY;
            overflow <= 1'b0;
        end else begin
            count    <= count_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: rtl/parking_exit_controller.sv
// Exit gate sequencer: request / open / pass / close.
// Owns the free-slot count that the entry side reads.
module parking_exit_controller
    import parking_pkg::*;
#(
    parameter logic [CAP_W-1:0] CAPACITY     = DEFAULT_CAPACITY,
    parameter int               OPEN_TIMEOUT = 64,
    parameter int               CLOSE_GUARD  = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    parking_exit_controller_if.slave bus
);

    localparam int TMR_MAX =
        (OPEN_TIMEOUT > CLOSE_GUARD) ? OPEN_TIMEOUT : CLOSE_GUARD;
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(CLOSE_GUARD - 1);

    exit_state_e      state_q;
    exit_state_e      state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             gate_q;
    logic             gate_d;
    logic             done_q;
    logic             done_d;
    logic             rej_q;
    logic             rej_d;
    logic             tmo_q;
    logic             tmo_d;
    logic             block_q;
    logic             block_d;
    logic             inc;
    logic [CAP_W-1:0] count;
    logic             overflow;

    slot_counter #(
        .CAPACITY (CAPACITY)
    ) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc),
        .dec      (bus.entry_taken),
        .count    (count),
        .overflow (overflow)
    );

    // Next state, timer and registered-output values for the gate FSM.
    // block_q suppresses repeat rejects until exit_req drops again.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gate_d  = 1'b0;
        done_d  = 1'b0;
        rej_d   = 1'b0;
        tmo_d   = 1'b0;
        inc     = 1'b0;
        block_d = bus.exit_req ? block_q : 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.exit_req) begin
                    if (count < CAPACITY) begin
                        state_d = OPEN;
                        gate_d  = 1'b1;
                    end else if (!block_q) begin
                        rej_d   = 1'b1;
                        block_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (bus.car_passed) begin
                    state_d = CLOSING;
                    timer_d = '0;
                    done_d  = 1'b1;
                    inc     = 1'b1;
                end else if (timer_q == OPEN_LAST) begin
                    state_d = CLOSING;
                    timer_d = '0;
                    tmo_d   = 1'b1;
                end else begin
                    gate_d  = 1'b1;
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            CLOSING: begin
                if (timer_q == GUARD_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // FSM state, timer and output registers; reset drops the gate at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
            tmo_q   <= 1'b0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
            tmo_q   <= tmo_d;
            block_q <= block_d;
        end
    end

    assign bus.parking_capacity = count;
    assign bus.gate_open        = gate_q;
    assign bus.exit_done        = done_q;
    assign bus.exit_reject      = rej_q;
    assign bus.err_timeout      = tmo_q;
    assign bus.err_overflow     = overflow;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed bench for the parking exit controller.
// Each task drives one scenario and compares against hand-derived values.
module tb_parking_exit_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    parking_exit_controller_if bus ();

    parking_exit_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b1;
        bus.exit_req    = 1'b0;
        bus.car_passed  = 1'b0;
        bus.entry_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.parking_capacity !== 8'd200) begin
            errors++;
            $display("FAIL reset_cap: got %0d want 200",
                     bus.parking_capacity);
        end
        checks++;
        if (bus.gate_open !== 1'b0) begin
            errors++;
            $display("FAIL reset_gate: got %b want 0", bus.gate_open);
        end
        checks++;
        if ({bus.exit_done, bus.exit_reject, bus.err_timeout}
            !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b%b%b want 000",
                     bus.exit_done, bus.exit_reject, bus.err_timeout);
        end
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", bus.err_overflow);
        end
    endtask

    task automatic test_entry();
        bus.entry_taken = 1'b1;
        step();
        bus.entry_taken = 1'b0;
        checks++;
        if (bus.parking_capacity !== 8'd199) begin
            errors++;
            $display("FAIL entry_cap: got %0d want 199",
                     bus.parking_capacity);
        end
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL entry_ovf: got %b want 0", bus.err_overflow);
        end
    endtask

    task automatic test_exit();
        bus.exit_req = 1'b1;
        step();
        bus.exit_req = 1'b0;
        checks++;
        if (bus.gate_open !== 1'b1) begin
            errors++;
            $display("FAIL exit_open: got %b want 1", bus.gate_open);
        end
        repeat (4) step();
        bus.car_passed = 1'b1;
        step();
        bus.car_passed = 1'b0;
        checks++;
        if (bus.exit_done !== 1'b1) begin
            errors++;
            $display("FAIL exit_done: got %b want 1", bus.exit_done);
        end
        checks++;
        if (bus.parking_capacity !== 8'd200) begin
            errors++;
            $display("FAIL exit_cap: got %0d want 200",
                     bus.parking_capacity);
        end
        checks++;
        if (bus.gate_open !== 1'b0) begin
            errors++;
            $display("FAIL exit_closed: got %b want 0", bus.gate_open);
        end
        // Request during the guard window must be ignored for 4 cycles.
        bus.exit_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if ({bus.exit_reject, bus.gate_open, bus.exit_done}
                !== 3'b000) begin
                errors++;
                $display("FAIL guard_%0d: got rej=%b gate=%b done=%b want 000",
                         k, bus.exit_reject, bus.gate_open, bus.exit_done);
            end
        end
        step();
        checks++;
        if (bus.exit_reject !== 1'b1) begin
            errors++;
            $display("FAIL guard_idle_rej: got %b want 1", bus.exit_reject);
        end
        step();
        checks++;
        if (bus.exit_reject !== 1'b0) begin
            errors++;
            $display("FAIL guard_rej_once: got %b want 0", bus.exit_reject);
        end
        bus.exit_req = 1'b0;
        step();
    endtask

    task automatic test_reject();
        int rej_cnt;
        int gate_cnt;
        rej_cnt  = 0;
        gate_cnt = 0;
        bus.exit_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.exit_reject === 1'b1) rej_cnt++;
            if (bus.gate_open !== 1'b0) gate_cnt++;
        end
        bus.exit_req = 1'b0;
        checks++;
        if (rej_cnt !== 1) begin
            errors++;
            $display("FAIL reject_count: got %0d want 1", rej_cnt);
        end
        checks++;
        if (gate_cnt !== 0) begin
            errors++;
            $display("FAIL reject_gate: got %0d open cycles want 0",
                     gate_cnt);
        end
        step();
        bus.car_passed = 1'b1;
        step();
        bus.car_passed = 1'b0;
        checks++;
        if ({bus.parking_capacity, bus.exit_done, bus.err_overflow}
            !== {8'd200, 2'b00}) begin
            errors++;
            $display("FAIL idle_pass: got cap=%0d done=%b ovf=%b want 200 0 0",
                     bus.parking_capacity, bus.exit_done, bus.err_overflow);
        end
    endtask

    task automatic test_back_to_back();
        bus.entry_taken = 1'b1;
        repeat (2) step();
        bus.entry_taken = 1'b0;
        checks++;
        if (bus.parking_capacity !== 8'd198) begin
            errors++;
            $display("FAIL b2b_cap0: got %0d want 198",
                     bus.parking_capacity);
        end
        bus.exit_req = 1'b1;
        step();
        bus.car_passed = 1'b1;
        step();
        bus.car_passed = 1'b0;
        checks++;
        if (bus.parking_capacity !== 8'd199) begin
            errors++;
            $display("FAIL b2b_cap1: got %0d want 199",
                     bus.parking_capacity);
        end
        repeat (4) step();
        checks++;
        if (bus.gate_open !== 1'b0) begin
            errors++;
            $display("FAIL b2b_guard: got %b want 0", bus.gate_open);
        end
        step();
        checks++;
        if (bus.gate_open !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reopen: got %b want 1", bus.gate_open);
        end
        bus.car_passed = 1'b1;
        step();
        bus.car_passed = 1'b0;
        checks++;
        if ({bus.parking_capacity, bus.exit_done} !== {8'd200, 1'b1}) begin
            errors++;
            $display("FAIL b2b_cap2: got cap=%0d done=%b want 200 1",
                     bus.parking_capacity, bus.exit_done);
        end
        repeat (5) step();
        checks++;
        if (bus.exit_reject !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reject: got %b want 1", bus.exit_reject);
        end
        bus.exit_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int  open_cnt;
        logic closed;
        bus.entry_taken = 1'b1;
        repeat (50) step();
        bus.entry_taken = 1'b0;
        checks++;
        if (bus.parking_capacity !== 8'd150) begin
            errors++;
            $display("FAIL tmo_cap0: got %0d want 150",
                     bus.parking_capacity);
        end
        bus.exit_req = 1'b1;
        step();
        bus.exit_req = 1'b0;
        open_cnt = (bus.gate_open === 1'b1) ? 1 : 0;
        closed   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.gate_open === 1'b1) begin
                open_cnt++;
            end else begin
                closed = 1'b1;
                break;
            end
        end
        checks++;
        if (!closed || open_cnt !== 64) begin
            errors++;
            $display("FAIL tmo_len: got %0d open cycles closed=%b want 64",
                     open_cnt, closed);
        end
        checks++;
        if (bus.err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse: got %b want 1", bus.err_timeout);
        end
        checks++;
        if ({bus.parking_capacity, bus.exit_done} !== {8'd150, 1'b0}) begin
            errors++;
            $display("FAIL tmo_cap: got cap=%0d done=%b want 150 0",
                     bus.parking_capacity, bus.exit_done);
        end
        step();
        checks++;
        if (bus.err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_single: got %b want 0", bus.err_timeout);
        end
        repeat (5) step();
    endtask

    task automatic test_simultaneous();
        bus.exit_req = 1'b1;
        step();
        bus.exit_req = 1'b0;
        repeat (2) step();
        bus.car_passed  = 1'b1;
        bus.entry_taken = 1'b1;
        step();
        bus.car_passed  = 1'b0;
        bus.entry_taken = 1'b0;
        checks++;
        if (bus.parking_capacity !== 8'd150) begin
            errors++;
            $display("FAIL sim_cap: got %0d want 150",
                     bus.parking_capacity);
        end
        checks++;
        if (bus.exit_done !== 1'b1) begin
            errors++;
            $display("FAIL sim_done: got %b want 1", bus.exit_done);
        end
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL sim_ovf: got %b want 0", bus.err_overflow);
        end
        repeat (5) step();
    endtask

    task automatic test_underflow_reset();
        bus.entry_taken = 1'b1;
        repeat (150) step();
        bus.entry_taken = 1'b0;
        checks++;
        if ({bus.parking_capacity, bus.err_overflow} !== {8'd0, 1'b0}) begin
            errors++;
            $display("FAIL uf_cap0: got cap=%0d ovf=%b want 0 0",
                     bus.parking_capacity, bus.err_overflow);
        end
        bus.entry_taken = 1'b1;
        step();
        bus.entry_taken = 1'b0;
        checks++;
        if ({bus.parking_capacity, bus.err_overflow} !== {8'd0, 1'b1}) begin
            errors++;
            $display("FAIL uf_flag: got cap=%0d ovf=%b want 0 1",
                     bus.parking_capacity, bus.err_overflow);
        end
        step();
        checks++;
        if (bus.err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_sticky: got %b want 1", bus.err_overflow);
        end
        bus.exit_req = 1'b1;
        step();
        checks++;
        if (bus.gate_open !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_open: got %b want 1", bus.gate_open);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gate_open !== 1'b0) begin
            errors++;
            $display("FAIL rst_gate: got %b want 0", bus.gate_open);
        end
        checks++;
        if ({bus.parking_capacity, bus.err_overflow} !== {8'd200, 1'b0}) begin
            errors++;
            $display("FAIL rst_state: got cap=%0d ovf=%b want 200 0",
                     bus.parking_capacity, bus.err_overflow);
        end
        bus.exit_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.gate_open, bus.parking_capacity} !== {1'b0, 8'd200}) begin
            errors++;
            $display("FAIL rst_release: got gate=%b cap=%0d want 0 200",
                     bus.gate_open, bus.parking_capacity);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_entry();
        test_exit();
        test_reject();
        test_back_to_back();
        test_timeout();
        test_simultaneous();
        test_underflow_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
